// File: rtl/line_cmd_dispatcher.sv
// line_cmd_dispatcher: pops command words from the graphics FIFO, decodes LINE
// and SET_FRAME_BASE, and runs the line engine load sequence
// (color, point0, point1, trigger) one line at a time.
// Optional macro LD_STATS_EN enables the line_count / stall_cycles counters.
module line_cmd_dispatcher #(
    parameter int unsigned FB_WIDTH           = 800,
    parameter int unsigned FB_HEIGHT          = 600,
    parameter logic [31:0] DEFAULT_FRAME_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_din,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        LE_ready,
    output logic [31:0] LE_color,
    output logic [19:0] LE_point,
    output logic        LE_color_valid,
    output logic        LE_point0_valid,
    output logic        LE_point1_valid,
    output logic        LE_trigger,
    output logic [31:0] LE_frame_base,
    output logic        busy,
    output logic        cmd_err,
    output logic [15:0] line_count,
    output logic [31:0] stall_cycles
);

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LINE     = 8'h01;
    localparam logic [7:0] OP_SET_BASE = 8'h02;
    localparam logic [9:0] X_MAX       = 10'(FB_WIDTH - 1);
    localparam logic [9:0] Y_MAX       = 10'(FB_HEIGHT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_GET_COLOR,
        S_GET_P0,
        S_GET_P1,
        S_GET_BASE,
        S_WAIT_LE,
        S_SEND_COLOR,
        S_SEND_P0,
        S_SEND_P1,
        S_SEND_TRIG,
        S_WAIT_START,
        S_WAIT_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] color_q, color_d;
    logic [19:0] p0_q, p0_d;
    logic [19:0] p1_q, p1_d;
    logic [19:0] point_q, point_d;
    logic [31:0] frame_base_q, frame_base_d;
    logic        err_q, err_d;
    logic        color_valid_q, color_valid_d;
    logic        p0_valid_q, p0_valid_d;
    logic        p1_valid_q, p1_valid_d;
    logic        trigger_q, trigger_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_c;
    logic        hs_c;
    logic [19:0] point_clamped_c;

    // Clamp a point word's coordinates into the visible frame.
    function automatic logic [19:0] clamp_point(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] cx;
        logic [9:0] cy;
        cx = (x > X_MAX) ? X_MAX : x;
        cy = (y > Y_MAX) ? Y_MAX : y;
        return {cx, cy};
    endfunction

    // Word-accepting states; held low while reset is asserted.
    always_comb begin
        cmd_ready_c = 1'b0;
        case (state_q)
            S_FETCH, S_GET_COLOR, S_GET_P0, S_GET_P1, S_GET_BASE: cmd_ready_c = ~rst;
            default:                                              cmd_ready_c = 1'b0;
        endcase
    end

    assign hs_c            = cmd_valid & cmd_ready_c;
    assign point_clamped_c = clamp_point(cmd_din[25:16], cmd_din[9:0]);

    // Next-state, data capture and registered-output decode.
    always_comb begin
        state_d      = state_q;
        color_d      = color_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        frame_base_d = frame_base_q;
        err_d        = err_q;

        case (state_q)
            S_FETCH: begin
                if (hs_c) begin
                    case (cmd_din[31:24])
                        OP_NOP:      state_d = S_FETCH;
                        OP_LINE:     state_d = S_GET_COLOR;
                        OP_SET_BASE: state_d = S_GET_BASE;
                        default:     err_d   = 1'b1;
                    endcase
                end
            end
            S_GET_COLOR: begin
                if (hs_c) begin
                    color_d = cmd_din[23:0];
                    state_d = S_GET_P0;
                end
            end
            S_GET_P0: begin
                if (hs_c) begin
                    p0_d    = point_clamped_c;
                    state_d = S_GET_P1;
                end
            end
            S_GET_P1: begin
                if (hs_c) begin
                    p1_d    = point_clamped_c;
                    state_d = S_WAIT_LE;
                end
            end
            S_GET_BASE: begin
                if (hs_c) begin
                    frame_base_d = cmd_din;
                    state_d      = S_FETCH;
                end
            end
            S_WAIT_LE:    if (LE_ready) state_d = S_SEND_COLOR;
            S_SEND_COLOR: state_d = S_SEND_P0;
            S_SEND_P0:    state_d = S_SEND_P1;
            S_SEND_P1:    state_d = S_SEND_TRIG;
            S_SEND_TRIG:  state_d = S_WAIT_START;
            S_WAIT_START: if (!LE_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE:  if (LE_ready) state_d = S_FETCH;
            default:      state_d = S_FETCH;
        endcase

        color_valid_d = (state_d == S_SEND_COLOR);
        p0_valid_d    = (state_d == S_SEND_P0);
        p1_valid_d    = (state_d == S_SEND_P1);
        trigger_d     = (state_d == S_SEND_TRIG);
        busy_d        = (state_d != S_FETCH);

        point_d = point_q;
        if (state_d == S_SEND_P0) begin
            point_d = p0_q;
        end else if (state_d == S_SEND_P1) begin
            point_d = p1_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            color_q       <= '0;
            p0_q          <= '0;
            p1_q          <= '0;
            point_q       <= '0;
            frame_base_q  <= DEFAULT_FRAME_BASE;
            err_q         <= 1'b0;
            color_valid_q <= 1'b0;
            p0_valid_q    <= 1'b0;
            p1_valid_q    <= 1'b0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_q       <= color_d;
            p0_q          <= p0_d;
            p1_q          <= p1_d;
            point_q       <= point_d;
            frame_base_q  <= frame_base_d;
            err_q         <= err_d;
            color_valid_q <= color_valid_d;
            p0_valid_q    <= p0_valid_d;
            p1_valid_q    <= p1_valid_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready       = cmd_ready_c;
    assign LE_color        = {8'h00, color_q};
    assign LE_point        = point_q;
    assign LE_color_valid  = color_valid_q;
    assign LE_point0_valid = p0_valid_q;
    assign LE_point1_valid = p1_valid_q;
    assign LE_trigger      = trigger_q;
    assign LE_frame_base   = frame_base_q;
    assign busy            = busy_q;
    assign cmd_err         = err_q;

`ifdef LD_STATS_EN
    logic [15:0] line_count_q, line_count_d;
    logic [31:0] stall_q, stall_d;
    logic        line_done_c;
    logic        stall_inc_c;

    // Completed-line and engine/FIFO stall accounting.
    always_comb begin
        line_done_c = (state_q == S_WAIT_DONE) && LE_ready;
        case (state_q)
            S_WAIT_LE, S_WAIT_START, S_WAIT_DONE:              stall_inc_c = 1'b1;
            S_GET_COLOR, S_GET_P0, S_GET_P1, S_GET_BASE:       stall_inc_c = ~cmd_valid;
            default:                                           stall_inc_c = 1'b0;
        endcase
        line_count_d = line_count_q + 16'(line_done_c);
        stall_d      = (stall_inc_c && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
    end

    // Counter registers; line_count wraps, stall saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_count_q <= '0;
            stall_q      <= '0;
        end else begin
            line_count_q <= line_count_d;
            stall_q      <= stall_d;
        end
    end

    assign line_count   = line_count_q;
    assign stall_cycles = stall_q;
`else
    assign line_count   = 16'd0;
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_line_cmd_dispatcher.sv
// Testbench for line_cmd_dispatcher: table of LINE commands plus directed
// sequences for frame base, bad opcodes, back-to-back lines and mid-line reset.
module tb_line_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_din;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        LE_ready;
    logic [31:0] LE_color;
    logic [19:0] LE_point;
    logic        LE_color_valid;
    logic        LE_point0_valid;
    logic        LE_point1_valid;
    logic        LE_trigger;
    logic [31:0] LE_frame_base;
    logic        busy;
    logic        cmd_err;
    logic [15:0] line_count;
    logic [31:0] stall_cycles;

    line_cmd_dispatcher dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_din         (cmd_din),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .LE_ready        (LE_ready),
        .LE_color        (LE_color),
        .LE_point        (LE_point),
        .LE_color_valid  (LE_color_valid),
        .LE_point0_valid (LE_point0_valid),
        .LE_point1_valid (LE_point1_valid),
        .LE_trigger      (LE_trigger),
        .LE_frame_base   (LE_frame_base),
        .busy            (busy),
        .cmd_err         (cmd_err),
        .line_count      (line_count),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] color_w;
        logic [31:0] p0_w;
        logic [31:0] p1_w;
        logic [31:0] exp_color;
        logic [19:0] exp_p0;
        logic [19:0] exp_p1;
    } line_vec_t;

    line_vec_t   vecs[3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_lines = 0;
    logic [31:0] exp_base = 32'h1000_0000;

    int eng_busy = 5;
    int eng_rise_cyc = 0;
    int trig_count = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model: drops LE_ready after a trigger, raises it eng_busy edges later.
    initial begin
        LE_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (LE_trigger === 1'b1) begin
                trig_count++;
                LE_ready = 1'b0;
                repeat (eng_busy) @(posedge clk);
                #1;
                LE_ready = 1'b1;
                eng_rise_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_lines();
`ifdef LD_STATS_EN
        chk("line_count", 64'(line_count), 64'(16'(exp_lines)));
`else
        chk("line_count_tied", 64'(line_count), 64'(0));
`endif
    endtask

    // Present one word and wait (bounded) for it to be accepted.
    task automatic send_word(input logic [31:0] w, output int acc);
        logic ok;
        ok  = 1'b0;
        acc = -1;
        cmd_din   = w;
        cmd_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("word_accept", 64'(ok), 64'(1));
    endtask

    // Issue one LINE and check strobe order, timing, data and completion.
    task automatic run_line(input line_vec_t v, input string tag);
        int acc, t;
        int c_at, p0_at, p1_at, tr_at, multi, s;
        logic done;
        c_at = -1; p0_at = -1; p1_at = -1; tr_at = -1; multi = 0; done = 1'b0;
        send_word(32'h01AB_CDEF, acc);
        send_word(v.color_w, t);
        send_word(v.p0_w, t);
        send_word(v.p1_w, t);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            s = int'(LE_color_valid) + int'(LE_point0_valid) + int'(LE_point1_valid) + int'(LE_trigger);
            if (s > 1) multi++;
            if (LE_color_valid) begin
                c_at = cyc - acc;
                chk({tag, "_color"}, 64'(LE_color), 64'(v.exp_color));
            end
            if (LE_point0_valid) begin
                p0_at = cyc - acc;
                chk({tag, "_p0"}, 64'(LE_point), 64'(v.exp_p0));
            end
            if (LE_point1_valid) begin
                p1_at = cyc - acc;
                chk({tag, "_p1"}, 64'(LE_point), 64'(v.exp_p1));
            end
            if (LE_trigger) tr_at = cyc - acc;
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_color_at"}, 64'(c_at), 64'(4));
        chk({tag, "_p0_at"}, 64'(p0_at), 64'(5));
        chk({tag, "_p1_at"}, 64'(p1_at), 64'(6));
        chk({tag, "_trig_at"}, 64'(tr_at), 64'(7));
        chk({tag, "_one_strobe"}, 64'(multi), 64'(0));
        chk({tag, "_point_hold"}, 64'(LE_point), 64'(v.exp_p1));
        chk({tag, "_base"}, 64'(LE_frame_base), 64'(exp_base));
        exp_lines++;
        chk_lines();
    endtask

    initial begin
        int t, acc2, rise1, t0, st0;
        logic done;

        vecs[0] = '{32'h00FF_8040, 32'h000A_0014, 32'h0064_0032,
                    32'h00FF_8040, 20'h02814, {10'd100, 10'd50}};
        vecs[1] = '{32'hAB12_3456, 32'hFC00_FC00, 32'h03FF_02BC,
                    32'h0012_3456, 20'h00000, {10'd799, 10'd599}};
        vecs[2] = '{32'h0000_0001, 32'h031F_0257, 32'h0320_0258,
                    32'h0000_0001, {10'd799, 10'd599}, {10'd799, 10'd599}};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_din = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_strobes", 64'({LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}), 64'(0));
        chk("rst_color", 64'(LE_color), 64'(0));
        chk("rst_point", 64'(LE_point), 64'(0));
        chk("rst_base", 64'(LE_frame_base), 64'(32'h1000_0000));
        chk("rst_err", 64'(cmd_err), 64'(0));
        chk("rst_stall", 64'(stall_cycles), 64'(0));
        chk_lines();
        rst = 1'b0;
        #1;
        chk("fetch_ready", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 3; i++) begin
            run_line(vecs[i], $sformatf("vec%0d", i));
        end

        // Frame base update, then reset restores default.
        send_word(32'h0200_0000, t);
        send_word(32'h1040_0000, t);
        exp_base = 32'h1040_0000;
        chk("fb_set", 64'(LE_frame_base), 64'(32'h1040_0000));
        chk("fb_idle", 64'(busy), 64'(0));
        run_line(vecs[0], "fbline");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_base = 32'h1000_0000;
        exp_lines = 0;
        chk("fb_reset", 64'(LE_frame_base), 64'(32'h1000_0000));
        chk_lines();

        // Unknown opcode then NOP then LINE.
        send_word(32'h7E00_0000, t);
        chk("bad_err", 64'(cmd_err), 64'(1));
        chk("bad_idle", 64'(busy), 64'(0));
        send_word(32'h0000_0000, t);
        chk("nop_err_sticky", 64'(cmd_err), 64'(1));
        chk("nop_idle", 64'(busy), 64'(0));
        run_line(vecs[1], "after_bad");
        chk("line_err_sticky", 64'(cmd_err), 64'(1));

        // Two LINEs back-to-back with a slow engine.
        eng_busy = 40;
        t0 = trig_count;
        st0 = int'(stall_cycles);
        send_word(32'h0100_0000, t);
        send_word(vecs[0].color_w, t);
        send_word(vecs[0].p0_w, t);
        send_word(vecs[0].p1_w, t);
        send_word(32'h0100_0000, acc2);
        rise1 = eng_rise_cyc;
        chk("b2b_first_trig", 64'(trig_count - t0), 64'(1));
        chk("b2b_no_overlap", 64'(acc2 > rise1), 64'(1));
        send_word(vecs[2].color_w, t);
        send_word(vecs[2].p0_w, t);
        send_word(vecs[2].p1_w, t);
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("b2b_done", 64'(done), 64'(1));
        chk("b2b_trigs", 64'(trig_count - t0), 64'(2));
        chk("b2b_last_point", 64'(LE_point), 64'(vecs[2].exp_p1));
        exp_lines += 2;
        chk_lines();
`ifdef LD_STATS_EN
        chk("b2b_stall_ge80", 64'((int'(stall_cycles) - st0) >= 80), 64'(1));
`else
        chk("stall_tied", 64'(stall_cycles), 64'(0));
`endif
        eng_busy = 5;

        // Reset asserted during SEND_P0.
        t0 = trig_count;
        send_word(32'h0100_0000, t);
        send_word(vecs[0].color_w, t);
        send_word(vecs[0].p0_w, t);
        send_word(vecs[0].p1_w, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_p0_strobe", 64'(LE_point0_valid), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_strobes", 64'({LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_point", 64'(LE_point), 64'(0));
        rst = 1'b0;
        exp_lines = 0;
        #1;
        chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
        chk("mid_rst_err", 64'(cmd_err), 64'(0));
        chk_lines();
        send_word(32'h0500_1234, t);
        chk("leftover_as_opcode", 64'(cmd_err), 64'(1));
        chk("leftover_idle", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_trig", 64'(trig_count - t0), 64'(0));
        chk("mid_rst_engine_idle", 64'(LE_ready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
